// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
//   - func3 encodings of the eight M-extension operations
//   - FSM state type
//   - legal range of the multiply occupancy parameter
//   - two's-complement helpers used by operand capture and result fixup
package muldiv_sequencer_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int unsigned MUL_CYCLES_MIN = 1;
    localparam int unsigned MUL_CYCLES_MAX = 8;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFixup,
        StDone
    } state_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of v when it is to be read as signed, raw value otherwise.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One iteration of a restoring divider (purely combinational).
//   i_rem     : partial remainder, 33 bits so the trial subtract's borrow is visible
//   i_quo     : dividend bits still to be consumed (MSB first), quotient bits shift in at LSB
//   i_divisor : divisor magnitude
//   o_rem     : next partial remainder
//   o_quo     : next dividend/quotient register
module muldiv_sequencer_div_step (
    input  logic [32:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_divisor,
    output logic [32:0] o_rem,
    output logic [31:0] o_quo
);

    logic [32:0] w_shifted;
    logic [32:0] w_diff;
    logic        w_unused_rem_msb;

    // The remainder is always below the divisor between steps, so its top bit is zero here.
    assign w_unused_rem_msb = i_rem[32];

    always_comb begin
        w_shifted = {i_rem[31:0], i_quo[31]};
        w_diff    = w_shifted - {1'b0, i_divisor};
        // Bit 32 set means the subtract borrowed: restore and shift in a zero.
        if (w_diff[32]) begin
            o_rem = w_shifted;
            o_quo = {i_quo[30:0], 1'b0};
        end else begin
            o_rem = w_diff;
            o_quo = {i_quo[30:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M execute-stage controller. Accepts one MUL/DIV request from EX, runs a
// registered multiplier or a 32-step restoring divider, stalls the pipeline meanwhile and
// presents a single registered result with a one-cycle done pulse.
//   i_clk    : clock, rising edge
//   i_reset  : synchronous, active-high reset
//   i_start  : EX holds a valid M-op (level, held while o_stall is high)
//   i_flush  : kill the in-flight op
//   i_func3  : operation select (MUL..REMU)
//   i_op_a   : rs1 value
//   i_op_b   : rs2 value
//   o_stall  : freeze PC/IF/ID/EX
//   o_done   : one-cycle pulse, o_result valid
//   o_result : registered result, held until the next accepted op completes
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned WIDTH      = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic [2:0]       i_func3,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_stall,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    if ((MUL_CYCLES < MUL_CYCLES_MIN) || (MUL_CYCLES > MUL_CYCLES_MAX)) begin : g_bad_mul_cycles
        $error("muldiv_sequencer: MUL_CYCLES must be in 1..8");
    end
    if (WIDTH != 32) begin : g_bad_width
        $error("muldiv_sequencer: only WIDTH=32 is supported");
    end

    localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_CNT_INIT = 5'd31;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [1:0]  r_func3_lo;
    logic        r_a_neg;
    logic        r_b_neg;
    logic [63:0] r_product;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_divisor;
    logic [31:0] r_result;
    logic        r_done;

    logic        w_a_signed;
    logic        w_b_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_product;
    logic        w_is_div;
    logic        w_is_rem;
    logic        w_special;
    logic [31:0] w_special_result;
    logic [31:0] w_mul_result;
    logic [31:0] w_div_result;
    logic [32:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic        w_idle_req;

    // Operand signedness per operation; the divide ops reuse it for magnitude/fixup.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (i_func3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            F3_MULHSU: begin
                w_a_signed = 1'b1;
            end
            F3_MULHU, F3_DIVU, F3_REMU: begin
                w_a_signed = 1'b0;
            end
            default: begin
                w_a_signed = 1'b0;
            end
        endcase
    end

    assign w_is_div = i_func3[2];
    assign w_is_rem = i_func3[1];

    // Sign-extending both operands to 64 bits makes one 64x64 mod-2^64 multiply cover all
    // four signedness combinations.
    assign w_a_ext   = {{32{i_op_a[31] & w_a_signed}}, i_op_a};
    assign w_b_ext   = {{32{i_op_b[31] & w_b_signed}}, i_op_b};
    assign w_product = w_a_ext * w_b_ext;

    // Divide-by-zero and signed overflow resolve without iterating.
    always_comb begin
        w_special        = 1'b0;
        w_special_result = 32'd0;
        if (w_is_div) begin
            if (i_op_b == 32'd0) begin
                w_special        = 1'b1;
                w_special_result = w_is_rem ? i_op_a : 32'hFFFF_FFFF;
            end else if (w_a_signed && (i_op_a == 32'h8000_0000) && (i_op_b == 32'hFFFF_FFFF)) begin
                w_special        = 1'b1;
                w_special_result = w_is_rem ? 32'd0 : 32'h8000_0000;
            end
        end
    end

    assign w_mul_result = (r_func3_lo == 2'b00) ? r_product[31:0] : r_product[63:32];

    always_comb begin
        if (r_func3_lo[1]) begin
            w_div_result = r_a_neg ? neg32(r_rem[31:0]) : r_rem[31:0];
        end else begin
            w_div_result = (r_a_neg ^ r_b_neg) ? neg32(r_quo) : r_quo;
        end
    end

    muldiv_sequencer_div_step u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_quo     (w_quo_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_cnt      <= 5'd0;
            r_func3_lo <= 2'b00;
            r_a_neg    <= 1'b0;
            r_b_neg    <= 1'b0;
            r_product  <= 64'd0;
            r_rem      <= 33'd0;
            r_quo      <= 32'd0;
            r_divisor  <= 32'd0;
            r_result   <= 32'd0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_flush) begin
                r_state <= StIdle;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (i_start) begin
                            r_func3_lo <= i_func3[1:0];
                            r_a_neg    <= w_a_signed & i_op_a[31];
                            r_b_neg    <= w_b_signed & i_op_b[31];
                            r_product  <= w_product;
                            r_rem      <= 33'd0;
                            r_quo      <= mag32(i_op_a, w_a_signed);
                            r_divisor  <= mag32(i_op_b, w_b_signed);
                            if (w_special) begin
                                r_result <= w_special_result;
                                r_done   <= 1'b1;
                                r_state  <= StDone;
                            end else if (!w_is_div) begin
                                r_cnt   <= MUL_CNT_INIT;
                                r_state <= StMul;
                            end else begin
                                r_cnt   <= DIV_CNT_INIT;
                                r_state <= StDiv;
                            end
                        end
                    end
                    StMul: begin
                        if (r_cnt == 5'd0) begin
                            r_result <= w_mul_result;
                            r_done   <= 1'b1;
                            r_state  <= StDone;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                    StDiv: begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        if (r_cnt == 5'd0) begin
                            r_state <= StFixup;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                    StFixup: begin
                        r_result <= w_div_result;
                        r_done   <= 1'b1;
                        r_state  <= StDone;
                    end
                    StDone: begin
                        // A start still high here belongs to the op that just finished.
                        r_state <= StIdle;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    // Combinational so EX freezes in the very cycle it presents the request.
    assign w_idle_req = (r_state == StIdle) && i_start;
    assign o_stall    = !i_reset && !i_flush &&
                        (w_idle_req || (r_state == StMul) || (r_state == StDiv) ||
                         (r_state == StFixup));
    assign o_done     = r_done;
    assign o_result   = r_result;

endmodule
